// File: rtl/n_bit_deserializer_if.sv
// n_bit_deserializer_if: serial bit input and word handshake bundle (perr exists only with DESER_PARITY_EN)
interface n_bit_deserializer_if #(parameter int N = 4, parameter int CW = 3);
    logic en;
    logic sin;
    logic dir;
    logic clr;
    logic ready;
    logic [N-1:0] out;
    logic valid;
    logic [CW-1:0] count;
    logic overrun;
`ifdef DESER_PARITY_EN
    logic perr;
    modport master (output en, sin, dir, clr, ready, input out, valid, count, overrun, perr);
    modport slave (input en, sin, dir, clr, ready, output out, valid, count, overrun, perr);
`else
    modport master (output en, sin, dir, clr, ready, input out, valid, count, overrun);
    modport slave (input en, sin, dir, clr, ready, output out, valid, count, overrun);
`endif
endinterface

// File: rtl/n_bit_deserializer.sv
// n_bit_deserializer: assembles a serial bit stream into N-bit words on a valid/ready handshake; DESER_PARITY_EN adds an even-parity bit per frame
module n_bit_deserializer #(parameter int N = 4, parameter int CW = 3) (
    input logic clk,
    input logic res,
    n_bit_deserializer_if.slave bus
);
`ifdef DESER_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(N);
`else
    localparam bit PAR = 1'b0;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
`endif
    typedef enum logic [1:0] {EMPTY, COLLECT, FULL} state_t;
    state_t state;
    logic [N-1:0] sr, sr_n, sr_sh, word, out_n;
    logic [CW-1:0] count_n;
    logic ord, ord_n, ord_cur, accept, last, good, deliver, valid_n, overrun_n, perr_n;
    // progress view, datapath steering and next-state computation
    always_comb begin
        state = bus.valid ? FULL : (bus.count != '0) ? COLLECT : EMPTY;
        deliver = (state == FULL) && bus.ready;
        accept = bus.en && !bus.clr;
        last = accept && (bus.count == LAST);
        ord_cur = (bus.count == '0) ? bus.dir : ord;
        sr_sh = ord_cur ? {bus.sin, sr[N-1:1]} : {sr[N-2:0], bus.sin};
        word = PAR ? sr : sr_sh;
        good = !PAR || !(^{sr, bus.sin});
        sr_n = sr;
        count_n = bus.count;
        ord_n = ord;
        out_n = bus.out;
        valid_n = bus.valid;
        overrun_n = bus.overrun;
        perr_n = 1'b0;
        if (bus.clr) begin
            sr_n = '0;
            count_n = '0;
            valid_n = 1'b0;
            overrun_n = 1'b0;
        end else begin
            if (deliver) valid_n = 1'b0;
            if (accept) begin
                ord_n = ord_cur;
                count_n = last ? '0 : bus.count + CW'(1);
                sr_n = (PAR && last) ? sr : sr_sh;
                perr_n = last && !good;
                if (last && good) begin
                    if (!bus.valid || deliver) begin
                        out_n = word;
                        valid_n = 1'b1;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
        end
    end
    // state registers, cleared asynchronously so a partial word is discarded
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sr <= '0;
            ord <= 1'b0;
            bus.out <= '0;
            bus.valid <= 1'b0;
            bus.count <= '0;
            bus.overrun <= 1'b0;
        end else begin
            sr <= sr_n;
            ord <= ord_n;
            bus.out <= out_n;
            bus.valid <= valid_n;
            bus.count <= count_n;
            bus.overrun <= overrun_n;
        end
    end
`ifdef DESER_PARITY_EN
    // one-cycle pulse after a frame completes with odd parity
    always_ff @(posedge clk or posedge res) begin
        if (res) bus.perr <= 1'b0;
        else bus.perr <= perr_n;
    end
`else
    logic unused_perr;
    assign unused_perr = perr_n;
`endif
endmodule

// File: tb/tb_n_bit_deserializer.sv
// tb_n_bit_deserializer: scoreboard bench; delivered words are popped from an expected queue on each handshake
module tb_n_bit_deserializer;
    localparam int N = 4;
    localparam int CW = 3;
`ifdef DESER_PARITY_EN
    localparam int FR = N + 1;
`else
    localparam int FR = N;
`endif
    logic clk = 1'b0;
    logic res = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    n_bit_deserializer_if #(.N(N), .CW(CW)) bus ();
    n_bit_deserializer #(.N(N), .CW(CW)) dut (.clk(clk), .res(res), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    // scoreboard: every handshake must deliver the oldest expected word
    always @(negedge clk) begin
        if (!res && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) check("spurious_word", bus.valid, 0);
            else check("word", bus.out, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b, input logic d);
        bus.en = 1'b1;
        bus.sin = b;
        bus.dir = d;
        tick();
        bus.en = 1'b0;
    endtask

    // bits[N-1] goes out first; fin_rdy is applied before the frame's final bit
    task automatic send_bits(input logic [N-1:0] bits, input logic d, input bit push, input logic bad, input logic fin_rdy);
        for (int i = N - 1; i >= 0; i--) begin
            if (FR == N && i == 0) bus.ready = fin_rdy;
            bit_in(bits[i], d);
        end
        if (FR != N) begin
            bus.ready = fin_rdy;
            bit_in(^bits ^ bad, d);
        end
        if (push) exp_q.push_back(d ? rev(bits) : bits);
    endtask

    initial begin
        logic [N-1:0] bits;
        int expc;
        bus.en = 1'b0;
        bus.sin = 1'b0;
        bus.dir = 1'b0;
        bus.clr = 1'b0;
        bus.ready = 1'b1;
        res = 1'b1;
        tick();
        tick();
        check("rst_out", bus.out, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_overrun", bus.overrun, 0);
        res = 1'b0;
        tick();
        // asynchronous reset discards a partial word
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        check("mid_count", bus.count, 2);
        #2 res = 1'b1;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_valid", bus.valid, 0);
        check("arst_out", bus.out, 0);
        res = 1'b0;
        send_bits(4'b1011, 1'b0, 1, 1'b0, 1'b1);
        check("after_rst_out", bus.out, 4'b1011);
        check("after_rst_valid", bus.valid, 1);
        tick();
        // MSB first then LSB first with the same bit sequence
        send_bits(4'b1101, 1'b0, 1, 1'b0, 1'b1);
        check("msb_valid", bus.valid, 1);
        check("msb_out", bus.out, 4'b1101);
        tick();
        check("msb_delivered", bus.valid, 0);
        send_bits(4'b1101, 1'b1, 1, 1'b0, 1'b1);
        check("lsb_out", bus.out, 4'b1011);
        tick();
        // gapped enable with dir flipping mid-word
        bits = 4'b0111;
        expc = 0;
        exp_q.push_back(bits);
        for (int i = 0; i < N; i++) begin
            bus.en = 1'b1;
            bus.sin = bits[N-1-i];
            bus.dir = (i >= 2);
            tick();
            bus.en = 1'b0;
            expc = (expc + 1) % FR;
            check("gap_count", bus.count, expc);
            tick();
            check("gap_hold", bus.count, expc);
        end
        if (FR != N) begin
            bit_in(^bits, 1'b1);
            check("gap_par_count", bus.count, 0);
            tick();
        end
        check("gap_out", bus.out, 4'b0111);
        // backpressure drops the second word and latches overrun
        bus.ready = 1'b0;
        send_bits(4'b1010, 1'b0, 1, 1'b0, 1'b0);
        send_bits(4'b0110, 1'b0, 0, 1'b0, 1'b0);
        check("bp_out", bus.out, 4'b1010);
        check("bp_valid", bus.valid, 1);
        check("bp_overrun", bus.overrun, 1);
        bus.ready = 1'b1;
        tick();
        check("bp_drain_valid", bus.valid, 0);
        check("bp_sticky", bus.overrun, 1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_overrun", bus.overrun, 0);
        check("clr_out_hold", bus.out, 4'b1010);
        // clr wins over en and drops the presented bit
        bit_in(1'b1, 1'b0);
        bus.clr = 1'b1;
        bit_in(1'b1, 1'b0);
        bus.clr = 1'b0;
        check("clr_count", bus.count, 0);
        // delivery and completion on the same edge
        bus.ready = 1'b0;
        send_bits(4'b1010, 1'b0, 1, 1'b0, 1'b0);
        send_bits(4'b0011, 1'b0, 1, 1'b0, 1'b1);
        check("sim_out", bus.out, 4'b0011);
        check("sim_valid", bus.valid, 1);
        check("sim_overrun", bus.overrun, 0);
        tick();
        check("sim_drain", bus.valid, 0);
`ifdef DESER_PARITY_EN
        send_bits(4'b1011, 1'b0, 0, 1'b1, 1'b1);
        check("perr_pulse", bus.perr, 1);
        check("perr_valid", bus.valid, 0);
        tick();
        check("perr_clear", bus.perr, 0);
`endif
        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
